layer_desc_fetch: RTL and testbench
===================================

# layer_desc_fetch

Downstream sequencer for the PS→PL mailbox stage. On each mailbox hit (`transfer_done` rising edge), it reads one 4-word layer descriptor from a descriptor BRAM through a BRAM-controller port. It offers the descriptor to the U-Net accelerator core with a valid/ready handshake and waits for the layer to finish. It then pulses `change_based_address` so the mailbox stage advances to its next slot.

## Interface
- `DESC_BASE`, default 32'h4581_0000: byte address of descriptor 0 in BRAM.
- `NUM_LAYERS`, default 8: descriptors per frame. Range 1..255.
- `RD_LAT`, default 2: BRAM read latency in cycles. Range 1..3.
- `clk` in 1: clock.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `transfer_done` in 1: level from the mailbox stage. High while the mailbox word matches the expected tag.
- `change_based_address` out 1: one-cycle pulse. Advances the mailbox stage's read pointer.
- `ram_clk` out 1: descriptor BRAM clock, equal to `clk`.
- `ram_rst` out 1: tied to 0.
- `ram_en` out 1: BRAM enable.
- `ram_we` out 4: tied to 0.
- `ram_wd_data` out 32: tied to 0.
- `ram_addr` out 32: BRAM byte address. Registered.
- `ram_rd_data` in 32: BRAM read data.
- `desc_valid` out 1: descriptor offered to the accelerator.
- `desc_ready` in 1: accelerator accepts the descriptor.
- `desc_src` out 32: descriptor word 0.
- `desc_dst` out 32: descriptor word 1.
- `desc_len` out 32: descriptor word 2.
- `desc_cfg` out 32: descriptor word 3.
- `layer_done` in 1: one-cycle pulse from the accelerator when the layer completes.
- `layer_idx` out 8: index of the current or next layer.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse after the last layer's ADV.
- `err_overrun` out 1: sticky error. Set when a trigger is lost.

## Operation
- Trigger: `trig = transfer_done & ~transfer_done_q`, where `transfer_done_q` is `transfer_done` registered one cycle. A level held high gives exactly one trigger.
- Pending flag: a trigger outside IDLE sets `pend`. A trigger while `pend` is already 1 sets `err_overrun`. `err_overrun` clears only on reset.
- `desc_ptr`: 32-bit register, reset to `DESC_BASE`.
- IDLE state:
  - Go to FETCH on `trig | pend`.
  - Clear `pend` on that transition.
- FETCH state:
  - Issue 4 reads on 4 consecutive cycles: `ram_addr = desc_ptr + 4*k`, k=0..3, with `ram_en=1`.
  - `ram_en=0` at all other times.
  - A shift pipeline of depth `RD_LAT` tags each returning word with k. Word k is captured into its `desc_*` register.
  - Go to OFFER the cycle after word 3 is captured.
- OFFER state:
  - `desc_valid=1`. `desc_*` are stable while in OFFER.
  - Go to RUN on the cycle where `desc_valid & desc_ready`. `desc_valid` drops the next cycle.
  - If `desc_ready` is already high on entry, the handshake completes in the entry cycle.
- RUN state:
  - Wait for `layer_done`, then go to ADV.
  - `layer_done` is ignored in every state other than RUN.
- ADV state (one cycle):
  - `change_based_address=1`.
  - `desc_ptr += 16` and `layer_idx += 1`.
  - If `layer_idx == NUM_LAYERS-1`: set `layer_idx` to 0, set `desc_ptr` to `DESC_BASE`, and pulse `frame_done` in the same cycle.
  - Go to IDLE.
- Arithmetic: `desc_ptr` and `ram_addr` wrap modulo 2^32. No overflow detection.
- Reset mid-operation: all state returns to reset values immediately. A handshake in progress is abandoned. The accelerator must also be reset.

## Timing
- Reset values:
  - `change_based_address`, `ram_en`, `desc_valid`, `busy`, `frame_done`, `err_overrun`: 0.
  - `desc_src`, `desc_dst`, `desc_len`, `desc_cfg`, `layer_idx`: 0.
  - `ram_addr`: `DESC_BASE`. FSM state: IDLE. `pend`: 0.
- Cycle numbering below: `transfer_done` rises at cycle 0.
  - Cycle 1: `trig` registered; FSM enters FETCH.
  - Cycles 2..5: read addresses 0..3 on the BRAM port.
  - Cycle 5+`RD_LAT`: last word captured.
  - Cycle 6+`RD_LAT`: `desc_valid` high. Default `RD_LAT=2` gives cycle 8.
- `layer_done` at cycle t (in RUN):
  - Cycle t+1: ADV, `change_based_address` high.
  - Cycle t+2: IDLE, `busy` low.
- Minimum spacing between triggers is FETCH + OFFER + RUN + ADV. One extra trigger may be buffered in `pend`.
- `transfer_done` and `trig` falling in the same cycle as ADV: `pend` is set, FSM goes to IDLE, then to FETCH the next cycle.

## Test plan
1. Single layer.
   - Stimulus: BRAM at `DESC_BASE` holds 11,22,33,44 (hex). Pulse `transfer_done`. Hold `desc_ready=1`. Pulse `layer_done` 5 cycles after the handshake.
   - Required response: `desc_valid` at cycle 8; `desc_src`..`desc_cfg` = 11,22,33,44; one `change_based_address` pulse; `layer_idx=1`; next read address 32'h4581_0010.
2. Backpressure.
   - Stimulus: hold `desc_ready=0` for 20 cycles.
   - Required response: `desc_valid` stays high and `desc_*` stay constant for the whole hold; a single handshake on the first `desc_ready=1` cycle.
3. Frame wrap.
   - Stimulus: `NUM_LAYERS=3`. Run 3 layers.
   - Required response: `frame_done` pulses in the 3rd ADV; `layer_idx=0`; the 4th trigger reads from 32'h4581_0000.
4. Pending and overrun.
   - Stimulus: one trigger during RUN, then a second trigger during RUN.
   - Required response: after the first, layer 2 starts fetching the cycle after leaving ADV→IDLE. After the second, `err_overrun=1` and stays high through later layers.
5. Held level and stray done.
   - Stimulus: hold `transfer_done` high for 50 cycles. Pulse `layer_done` in IDLE and in OFFER.
   - Required response: exactly one fetch; the stray `layer_done` pulses do not advance the FSM.
6. Reset mid-FETCH.
   - Stimulus: assert `rst_n=0` at cycle 3.
   - Required response: all outputs return to their reset values asynchronously; after release, a new trigger fetches from `DESC_BASE`.

Source files
------------

// File: rtl/layer_desc_fetch.sv
// layer_desc_fetch: on each mailbox trigger, reads one 4-word layer descriptor
// from BRAM, offers it to the accelerator with valid/ready, waits for the
// layer to finish, then pulses change_based_address to advance the mailbox.
module layer_desc_fetch #(
  parameter logic [31:0] DESC_BASE  = 32'h4581_0000,
  parameter int unsigned NUM_LAYERS = 8,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        transfer_done,
  output logic        change_based_address,
  output logic        ram_clk,
  output logic        ram_rst,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_wd_data,
  output logic [31:0] ram_addr,
  input  logic [31:0] ram_rd_data,
  output logic        desc_valid,
  input  logic        desc_ready,
  output logic [31:0] desc_src,
  output logic [31:0] desc_dst,
  output logic [31:0] desc_len,
  output logic [31:0] desc_cfg,
  input  logic        layer_done,
  output logic [7:0]  layer_idx,
  output logic        busy,
  output logic        frame_done,
  output logic        err_overrun
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_OFFER, S_RUN, S_ADV} state_e;

  localparam logic [7:0] LAST_IDX = 8'(NUM_LAYERS - 1);

  state_e      state_q, state_d;
  logic        td_q;
  logic        pend_q, pend_d;
  logic        err_q, err_d;
  logic [31:0] desc_ptr_q, desc_ptr_d;
  logic [7:0]  layer_idx_q, layer_idx_d;
  logic [2:0]  fetch_cnt_q, fetch_cnt_d;
  logic        ram_en_q, ram_en_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [1:0]  ram_k_q, ram_k_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, len_q, len_d, cfg_q, cfg_d;

  // Tag pipeline: word index travelling alongside each outstanding read.
  logic [RD_LAT-1:0] tag_vld_q;
  logic [1:0]        tag_k_q [RD_LAT];

  logic       trig;
  logic       cap_vld;
  logic [1:0] cap_k;

  assign trig    = transfer_done & ~td_q;
  assign cap_vld = tag_vld_q[RD_LAT-1];
  assign cap_k   = tag_k_q[RD_LAT-1];

  // Next-state, trigger bookkeeping, BRAM issue and descriptor capture.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    pend_d      = pend_q;
    err_d       = err_q;
    desc_ptr_d  = desc_ptr_q;
    layer_idx_d = layer_idx_q;
    fetch_cnt_d = fetch_cnt_q;
    ram_en_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_k_d     = ram_k_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    cfg_d       = cfg_q;

    // A trigger while busy is buffered once; a second one is lost.
    if (trig && state_q != S_IDLE) begin
      if (pend_q) err_d = 1'b1;
      pend_d = 1'b1;
    end

    if (cap_vld) begin
      unique case (cap_k)
        2'd0: src_d = ram_rd_data;
        2'd1: dst_d = ram_rd_data;
        2'd2: len_d = ram_rd_data;
        2'd3: cfg_d = ram_rd_data;
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        if (trig || pend_q) begin
          state_d     = S_FETCH;
          pend_d      = 1'b0;
          fetch_cnt_d = 3'd0;
        end
      end
      S_FETCH: begin
        if (fetch_cnt_q != 3'd4) begin
          ram_en_d    = 1'b1;
          ram_addr_d  = desc_ptr_q + {28'd0, fetch_cnt_q[1:0], 2'b00};
          ram_k_d     = fetch_cnt_q[1:0];
          fetch_cnt_d = fetch_cnt_q + 3'd1;
        end
        if (cap_vld && cap_k == 2'd3) state_d = S_OFFER;
      end
      S_OFFER: begin
        if (desc_ready) state_d = S_RUN;
      end
      S_RUN: begin
        if (layer_done) state_d = S_ADV;
      end
      S_ADV: begin
        state_d = S_IDLE;
        if (layer_idx_q == LAST_IDX) begin
          layer_idx_d = 8'd0;
          desc_ptr_d  = DESC_BASE;
        end else begin
          layer_idx_d = layer_idx_q + 8'd1;
          desc_ptr_d  = desc_ptr_q + 32'd16;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      td_q        <= 1'b0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      desc_ptr_q  <= DESC_BASE;
      layer_idx_q <= 8'd0;
      fetch_cnt_q <= 3'd0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= DESC_BASE;
      ram_k_q     <= 2'd0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      cfg_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      td_q        <= transfer_done;
      pend_q      <= pend_d;
      err_q       <= err_d;
      desc_ptr_q  <= desc_ptr_d;
      layer_idx_q <= layer_idx_d;
      fetch_cnt_q <= fetch_cnt_d;
      ram_en_q    <= ram_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_k_q     <= ram_k_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      cfg_q       <= cfg_d;
    end
  end

  // Delay each issued read's tag by the BRAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tag array is tiny and its valid bits gate capture, so it is
      // reset with everything else to drop in-flight reads immediately.
      tag_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_k_q[i] <= 2'd0;
    end else begin
      tag_vld_q[0] <= ram_en_q;
      tag_k_q[0]   <= ram_k_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_k_q[i]   <= tag_k_q[i-1];
      end
    end
  end

  assign ram_clk              = clk;
  assign ram_rst              = 1'b0;
  assign ram_we               = 4'b0000;
  assign ram_wd_data          = 32'd0;
  assign ram_en               = ram_en_q;
  assign ram_addr             = ram_addr_q;
  assign desc_valid           = (state_q == S_OFFER);
  assign desc_src             = src_q;
  assign desc_dst             = dst_q;
  assign desc_len             = len_q;
  assign desc_cfg             = cfg_q;
  assign change_based_address = (state_q == S_ADV);
  assign frame_done           = (state_q == S_ADV) && (layer_idx_q == LAST_IDX);
  assign layer_idx            = layer_idx_q;
  assign busy                 = (state_q != S_IDLE);
  assign err_overrun          = err_q;

endmodule

// File: tb/tb_layer_desc_fetch.sv
// Testbench for layer_desc_fetch: BRAM model, scoreboard queues filled by the
// stimulus thread, and a negedge monitor that pops and compares on every
// BRAM read burst, descriptor handshake and ADV pulse.
module tb_layer_desc_fetch;

  localparam logic [31:0] BASE = 32'h4581_0000;
  localparam int          NL   = 3;
  localparam int          RL   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        transfer_done;
  logic        change_based_address;
  logic        ram_clk, ram_rst, ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_wd_data, ram_addr, ram_rd_data;
  logic        desc_valid, desc_ready;
  logic [31:0] desc_src, desc_dst, desc_len, desc_cfg;
  logic        layer_done;
  logic [7:0]  layer_idx;
  logic        busy, frame_done, err_overrun;

  layer_desc_fetch #(.DESC_BASE(BASE), .NUM_LAYERS(NL), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .transfer_done(transfer_done),
    .change_based_address(change_based_address),
    .ram_clk(ram_clk), .ram_rst(ram_rst), .ram_en(ram_en), .ram_we(ram_we),
    .ram_wd_data(ram_wd_data), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len), .desc_cfg(desc_cfg),
    .layer_done(layer_done), .layer_idx(layer_idx), .busy(busy),
    .frame_done(frame_done), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- BRAM model: data appears RL cycles after the address
  logic [31:0] mem  [12];
  logic [31:0] hist [RL];
  always @(posedge clk) begin
    hist[0] <= ram_addr;
    for (int i = 1; i < RL; i++) hist[i] <= hist[i-1];
  end
  always_comb begin
    logic [31:0] off;
    off = hist[RL-1] - BASE;
    ram_rd_data = (off < 32'd48) ? mem[off[5:2]] : 32'hBAD0_BAD0;
  end

  // ---------------- checking
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0][31:0] w;
    logic [7:0]       idx;
  } desc_t;

  desc_t       desc_q [$];
  logic [31:0] addr_q [$];
  bit          frame_q[$];

  // Reference model: layer n reads BASE+16n; frame wraps after NL layers.
  int m_idx = 0;

  task automatic expect_layer(output desc_t d);
    for (int k = 0; k < 4; k++) d.w[k] = mem[4*m_idx + k];
    d.idx = 8'(m_idx);
    desc_q.push_back(d);
    addr_q.push_back(BASE + 32'(16*m_idx));
    frame_q.push_back(m_idx == NL-1);
    m_idx = (m_idx + 1) % NL;
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  int          mk = 0;
  logic [31:0] mbase = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mk = 0;
    end else begin
      if (ram_en) begin
        if (mk == 0) begin
          check("fetch_expected", 32'(addr_q.size() != 0), 32'd1);
          mbase = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hFFFF_FFFF;
        end
        check("ram_addr", ram_addr, mbase + 32'(4*mk));
        mk = (mk == 3) ? 0 : mk + 1;
      end
      if (desc_valid && desc_ready) begin
        desc_t e;
        check("handshake_expected", 32'(desc_q.size() != 0), 32'd1);
        if (desc_q.size() != 0) begin
          e = desc_q.pop_front();
          check("desc_src", desc_src, e.w[0]);
          check("desc_dst", desc_dst, e.w[1]);
          check("desc_len", desc_len, e.w[2]);
          check("desc_cfg", desc_cfg, e.w[3]);
          check("hs_layer_idx", 32'(layer_idx), 32'(e.idx));
        end
      end
      if (change_based_address) begin
        bit f;
        check("adv_expected", 32'(frame_q.size() != 0), 32'd1);
        f = (frame_q.size() != 0) ? frame_q.pop_front() : 1'b0;
        check("frame_done", 32'(frame_done), 32'(f));
      end else if (frame_done) begin
        check("frame_done_stray", 32'(frame_done), 32'd0);
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_td();
    transfer_done = 1'b1;
    tick();
    transfer_done = 1'b0;
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 60 && !desc_valid; n++) tick();
    check("desc_valid_wait", 32'(desc_valid), 32'd1);
  endtask

  task automatic handshake(input int rd, input desc_t d);
    int bad = 0;
    if (rd > 0) begin
      desc_ready = 1'b0;
      for (int i = 0; i < rd; i++) begin
        if (!desc_valid || desc_src !== d.w[0] || desc_dst !== d.w[1] ||
            desc_len !== d.w[2] || desc_cfg !== d.w[3]) bad++;
        tick();
      end
      check("bp_stable_cycles_bad", 32'(bad), 32'd0);
    end
    desc_ready = 1'b1;
    tick();
    desc_ready = 1'b0;
    check("valid_drops", 32'(desc_valid), 32'd0);
  endtask

  task automatic finish_layer(input int dd);
    repeat (dd) tick();
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    check("adv_pulse", 32'(change_based_address), 32'd1);
    tick();
    check("idle_after_adv", 32'(busy), 32'd0);
    check("layer_idx_after", 32'(layer_idx), 32'(m_idx));
  endtask

  task automatic run_layer(input int rd, input int dd);
    desc_t d;
    expect_layer(d);
    if (rd == 0) desc_ready = 1'b1;
    pulse_td();
    wait_valid();
    handshake(rd, d);
    finish_layer(dd);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    desc_t d, d2;
    int    n, start;

    rst_n = 1'b0; transfer_done = 1'b0; desc_ready = 1'b0; layer_done = 1'b0;
    for (int i = 0; i < 12; i++) mem[i] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    repeat (3) tick();

    // Reset values
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_ram_en",   32'(ram_en), 32'd0);
    check("rst_ram_addr", ram_addr, BASE);
    check("rst_valid",    32'(desc_valid), 32'd0);
    check("rst_src",      desc_src, 32'd0);
    check("rst_cfg",      desc_cfg, 32'd0);
    check("rst_idx",      32'(layer_idx), 32'd0);
    check("rst_err",      32'(err_overrun), 32'd0);
    check("rst_cba",      32'(change_based_address), 32'd0);
    check("ram_tie",      {ram_wd_data[27:0], ram_we}, 32'd0);
    check("ram_rst",      32'(ram_rst), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1. Single layer: valid at cycle 8, words 11..44, ready held high
    expect_layer(d);
    desc_ready = 1'b1;
    transfer_done = 1'b1;
    n = 0;
    while (!desc_valid && n < 60) begin
      tick();
      n++;
      transfer_done = 1'b0;
    end
    check("valid_cycle", 32'(n), 32'd8);
    check("t1_src", desc_src, 32'h11);
    check("t1_cfg", desc_cfg, 32'h44);
    tick();
    desc_ready = 1'b0;
    check("t1_valid_drops", 32'(desc_valid), 32'd0);
    finish_layer(4);
    check("t1_layer_idx", 32'(layer_idx), 32'd1);

    // 2. Backpressure for 20 cycles (fetch reads from BASE+0x10)
    run_layer(20, 3);

    // 3. Frame wrap on the third layer, next fetch from BASE
    run_layer(1, 2);
    check("t3_idx_wrap", 32'(layer_idx), 32'd0);

    // 4. Pending trigger, then an overrun
    expect_layer(d);
    pulse_td();
    wait_valid();
    handshake(1, d);
    expect_layer(d2);
    pulse_td();
    check("t4_no_err_yet", 32'(err_overrun), 32'd0);
    tick();
    pulse_td();
    check("t4_err_set", 32'(err_overrun), 32'd1);
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    check("t4_adv", 32'(change_based_address), 32'd1);
    tick();
    check("t4_idle", 32'(busy), 32'd0);
    tick();
    check("t4_pend_fetch", 32'(busy), 32'd1);
    wait_valid();
    handshake(2, d2);
    finish_layer(1);
    run_layer(0, 1);
    check("t4_err_sticky", 32'(err_overrun), 32'd1);

    // 5. Held level with stray layer_done in IDLE and OFFER
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    tick();
    check("t5_idle_stray_busy", 32'(busy), 32'd0);
    check("t5_idle_stray_idx", 32'(layer_idx), 32'(m_idx));
    start = cyc;
    expect_layer(d);
    transfer_done = 1'b1;
    wait_valid();
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    tick();
    check("t5_offer_stray", 32'(desc_valid), 32'd1);
    handshake(1, d);
    finish_layer(2);
    while (cyc - start < 50) tick();
    transfer_done = 1'b0;
    repeat (5) tick();
    check("t5_single_fetch", 32'(busy), 32'd0);

    // 6. Reset in the middle of FETCH
    expect_layer(d);
    transfer_done = 1'b1;
    tick();
    transfer_done = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy",   32'(busy), 32'd0);
    check("t6_ram_en", 32'(ram_en), 32'd0);
    check("t6_addr",   ram_addr, BASE);
    check("t6_idx",    32'(layer_idx), 32'd0);
    check("t6_err",    32'(err_overrun), 32'd0);
    check("t6_src",    desc_src, 32'd0);
    desc_q.delete();
    addr_q.delete();
    frame_q.delete();
    m_idx = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Randomized layers after reset (first one fetches from BASE)
    for (int i = 0; i < 12; i++) run_layer($urandom_range(0, 4), $urandom_range(0, 6));
    check("final_err_clear", 32'(err_overrun), 32'd0);

    repeat (5) tick();
    check("desc_q_drained", 32'(desc_q.size()), 32'd0);
    check("addr_q_drained", 32'(addr_q.size()), 32'd0);
    check("frame_q_drained", 32'(frame_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
